// File: rtl/aes_pkg.sv
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES-128 definitions: key-schedule FSM states, 32-bit word
//             type, round count, forward S-box table and Rcon lookup.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    // Number of rounds for AES-128
    localparam logic [3:0] NR = 4'd10;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Forward S-box; ascending packed index so SBOX[8'h00] is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for round r (1..10); zero elsewhere.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_subword.sv
// ============================================================================
//  Module   : aes_subword
//  Purpose  : Combinational AES SubWord - four parallel byte S-box lookups.
//             Shared between forward and backward key expansion.
//  Ports    : word_i [31:0] - input word
//             word_o [31:0] - S-box substituted word (byte-wise)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign word_o[8*g +: 8] = SBOX[word_i[8*g +: 8]];
    end

endmodule

`default_nettype wire

// File: rtl/aes_key_reverse.sv
// ============================================================================
//  Module   : aes_key_reverse
//  Purpose  : Backward AES-128 key schedule. Loads the round-10 key and emits
//             round keys 10 down to 0 on a valid/ready stream, one per cycle.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             start, last_key     - start request and round-10 key (IDLE only)
//             round_key/round_idx - current round key and its round number
//             round_key_valid     - stream valid
//             round_key_ready     - stream ready from consumer
//             busy, done          - run in progress / one-cycle completion
//  Config   : AES_KEYREV_ZEROIZE_EN - clear key material on completion and
//             mask round_key to zero whenever it is not valid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_reverse
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [127:0] key_q,   key_d;
    logic [3:0]   idx_q,   idx_d;

    word_t a0, a1, a2, a3;
    word_t b0, b1, b2, b3;
    word_t sub_w;

    assign a0 = key_q[127:96];
    assign a1 = key_q[95:64];
    assign a2 = key_q[63:32];
    assign a3 = key_q[31:0];

    // Undo the forward XOR chain first; b3 equals the previous key's last
    // word, which is what fed SubWord/RotWord in the forward direction.
    assign b3 = a3 ^ a2;
    assign b2 = a2 ^ a1;
    assign b1 = a1 ^ a0;

    aes_subword u_subword (
        .word_i ({b3[23:0], b3[31:24]}),
        .word_o (sub_w)
    );

    assign b0 = a0 ^ sub_w ^ {rcon(idx_q), 24'h0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        key_d           = key_q;
        idx_d           = idx_q;
        round_key_valid = 1'b0;
        done            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = NR;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                round_key_valid = 1'b1;
                if (round_key_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = {b0, b1, b2, b3};
                        idx_d = idx_q - 4'd1;
                    end else begin
                        state_d = ST_DONE;
`ifdef AES_KEYREV_ZEROIZE_EN
                        key_d   = '0;
`endif
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign round_idx = idx_q;

`ifdef AES_KEYREV_ZEROIZE_EN
    assign round_key = round_key_valid ? key_q : 128'h0;
`else
    assign round_key = key_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_key_reverse.sv
// ============================================================================
//  Module   : tb_aes_key_reverse
//  Purpose  : Self-checking bench for aes_key_reverse. A forward AES-128 key
//             expansion (S-box derived from GF(2^8) inversion) supplies the
//             expected round keys; a scoreboard checks the stream every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_reverse;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         round_key_valid;
    logic         round_key_ready;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_reverse dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .last_key        (last_key),
        .round_key       (round_key),
        .round_idx       (round_idx),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .busy            (busy),
        .done            (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [127:0] rk_m [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x, s;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[v] = s;
        end
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- scoreboard ----------------
    logic [127:0] exp_key [$];
    int           exp_idx [$];
    bit           done_pending = 0;
    bit           done_seen    = 0;

    always @(negedge clk) begin
        bit popped0;
        popped0 = 0;
        if (!reset) begin
            chk("busy", 128'(busy), 128'(exp_key.size() != 0 || done_pending));
            chk("done", 128'(done), 128'(done_pending));
            if (done) done_seen = 1;
            if (round_key_valid) begin
                if (exp_key.size() == 0) begin
                    chk("valid_when_idle", 128'(round_key_valid), 128'(0));
                end else begin
                    chk("stream_key", round_key, exp_key[0]);
                    chk("stream_idx", 128'(round_idx), 128'(exp_idx[0]));
                    if (round_key_ready) begin
                        popped0 = (exp_idx[0] == 0);
                        void'(exp_key.pop_front());
                        void'(exp_idx.pop_front());
                    end
                end
            end
`ifdef AES_KEYREV_ZEROIZE_EN
            else begin
                chk("masked_key", round_key, 128'h0);
            end
`endif
            done_pending = popped0;
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;   // 0: always ready, 1: alternate, 2: random

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       round_key_ready = 1'b1;
            1:       round_key_ready = ~round_key_ready;
            default: round_key_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] ck);
        expand(ck);
        done_seen = 0;
        start     = 1'b1;
        last_key  = rk_m[10];
        step();
        start     = 1'b0;
        last_key  = rnd128();
        for (int r = 10; r >= 0; r--) begin
            exp_key.push_back(rk_m[r]);
            exp_idx.push_back(r);
        end
    endtask

    task automatic check_keyreg(input string tag);
`ifdef AES_KEYREV_ZEROIZE_EN
        chk({tag, "_keyreg_zero"}, dut.key_q, 128'h0);
`else
        chk({tag, "_keyreg_k0"}, dut.key_q, rk_m[0]);
`endif
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_seen && n < 300) begin
            step();
            n++;
        end
        if (!done_seen) tmo({tag, "_done"});
        chk({tag, "_left"}, 128'(exp_key.size()), 128'(0));
        chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
        check_keyreg(tag);
    endtask

    task automatic wait_idx(input int target, input string tag);
        int n;
        n = 0;
        while (!(round_key_valid && round_idx == 4'(target)) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) tmo(tag);
    endtask

    localparam logic [127:0] FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        last_key        = '0;
        round_key_ready = 1'b0;

        build_sbox();
        expand(FIPS_CK);
        chk("model_sbox00", 128'(sb[8'h00]), 128'h63);
        chk("model_sbox53", 128'(sb[8'h53]), 128'hed);
        chk("model_k10", rk_m[10], FIPS_K10);
        chk("model_k9", rk_m[9], FIPS_K9);
        chk("model_k1", rk_m[1], FIPS_K1);

        repeat (3) step();
        chk("rst_key", round_key, 128'h0);
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_valid", 128'(round_key_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        reset = 1'b0;
        step();

        // FIPS-197 vector with exact cycle timing
        rdy_mode = 0;
        launch(FIPS_CK);
        chk("t1_valid", 128'(round_key_valid), 128'(1));
        chk("t1_idx", 128'(round_idx), 128'(10));
        chk("t1_key", round_key, FIPS_K10);
        step();
        chk("t2_idx", 128'(round_idx), 128'(9));
        chk("t2_key", round_key, FIPS_K9);
        repeat (9) step();
        chk("t11_idx", 128'(round_idx), 128'(0));
        chk("t11_key", round_key, FIPS_CK);
        step();
        chk("t12_done", 128'(done), 128'(1));
        chk("t12_valid", 128'(round_key_valid), 128'(0));
        step();
        chk("t13_done", 128'(done), 128'(0));
        chk("t13_busy", 128'(busy), 128'(0));
        check_keyreg("fips");

        // Backpressure: ready toggles every cycle
        rdy_mode = 1;
        launch(FIPS_CK);
        wait_done("bp");

        // Start while busy is ignored
        rdy_mode = 2;
        launch(rnd128());
        wait_idx(5, "wait_idx5");
        start    = 1'b1;
        last_key = rnd128();
        step();
        start    = 1'b0;
        chk("busy_after_restart", 128'(busy), 128'(1));
        wait_done("swb");

        // Reset mid-run
        launch(rnd128());
        wait_idx(6, "wait_idx6");
        reset = 1'b1;
        step();
        exp_key.delete();
        exp_idx.delete();
        done_pending = 0;
        chk("mid_rst_key", round_key, 128'h0);
        chk("mid_rst_idx", 128'(round_idx), 128'(0));
        chk("mid_rst_valid", 128'(round_key_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        reset = 1'b0;
        done_seen = 0;
        repeat (4) step();
        chk("no_done_after_rst", 128'(done_seen), 128'(0));
        launch(rnd128());
        wait_done("post_rst");

        // Reset and start together: reset wins
        reset    = 1'b1;
        start    = 1'b1;
        last_key = rnd128();
        step();
        chk("rst_start_valid", 128'(round_key_valid), 128'(0));
        chk("rst_start_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("rst_start_idle", 128'(busy), 128'(0));

        // Round-trip on random cipher keys with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 100; k++) begin
            launch(rnd128());
            wait_done("rand");
        end

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_key_reverse.md
# aes_key_reverse

Backward AES-128 key schedule for the decryption datapath. It takes the round-10 key (the last round key produced by forward expansion) and regenerates the round keys in descending order, 10 down to 0. The inverse cipher consumes these keys one per round, so no 176-byte key store is needed. Keys are delivered through a valid/ready stream, one per cycle when the consumer is ready.

## Interface
Parameters:
- none; the block is fixed to AES-128 (Nk=4, Nr=10).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- last_key  input  128  round-10 key; bits [127:96] = word 0, [31:0] = word 3; sampled on the cycle start is accepted.
- round_key  output  128  current round key, same word ordering as last_key.
- round_idx  output  4  round number of round_key, 10..0.
- round_key_valid  output  1  round_key/round_idx are meaningful.
- round_key_ready  input  1  consumer accepts; a transfer occurs when valid && ready.
- busy  output  1  high from the accept of start until done.
- done  output  1  one-cycle pulse after the round-0 transfer.

## Operation
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 → load key_reg ← last_key, idx ← 10; go to EMIT.
  - start=0 → stay.
- EMIT:
  - round_key_valid=1, round_key=key_reg, round_idx=idx.
  - On transfer with idx≠0: key_reg ← prev(key_reg, idx), idx ← idx−1; stay in EMIT.
  - On transfer with idx=0: go to DONE.
  - No transfer: hold key_reg and idx unchanged; valid stays high (no retraction).
- DONE: done=1 for one cycle, then IDLE.
- prev(), with current key words a0..a3 and idx=r:
  - b3=a3^a2, b2=a2^a1, b1=a1^a0.
  - b0=a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r],24'h0}.
  - RotWord({x0,x1,x2,x3}) = {x1,x2,x3,x0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - Result is {b0,b1,b2,b3}.
- b3 is computed before SubWord, so the path is XOR → 4 S-boxes → XOR, purely combinational within one cycle.
- start while busy is ignored; last_key changes while busy have no effect.
- busy = (state≠IDLE). It is deasserted in the cycle after DONE, i.e. when the FSM is back in IDLE.

## Timing
- Reset values: round_key=0, round_idx=0, round_key_valid=0, busy=0, done=0; state=IDLE.
- start accepted at edge T → round 10 key valid from T+1.
- With ready held high: keys 10..0 are presented on cycles T+1..T+11, done on T+12, and a new start is accepted at T+13.
- Throughput is one key per cycle; each ready-low cycle adds exactly one cycle of stall.
- Reset mid-operation: at the next edge the block returns to IDLE with all outputs at reset values. No done pulse is produced.
- start and reset asserted together: reset wins.
- round_idx never wraps below 0; the DONE transition occurs before any decrement from 0.

## Configuration
- AES_KEYREV_ZEROIZE_EN defined:
  - On entry to DONE and on reset, key_reg is cleared to 0.
  - round_key reads 0 whenever round_key_valid=0, so no key material stays visible after use.
- Undefined:
  - key_reg retains the round-0 key after completion.
  - round_key is undefined-but-stable when valid=0. Only reset clears it.

## Structure
- Shared package aes_pkg holds:
  - the state enum;
  - a 32-bit word typedef;
  - the Rcon lookup function indexed by round;
  - the round-count constant NR=10.
- Sub-module aes_subword: combinational, 32-bit in/out, four byte S-boxes. It is shared with the forward expansion.
- Top module holds the FSM, key_reg, idx, and the prev() XOR network.

## Test plan
- FIPS-197 vector: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1.
  - Cycle T+1: round_idx=10 with that key.
  - T+2: round_idx=9, ac7766f319fadc2128d12941575c006e.
  - T+11: round_idx=0, 2b7e151628aed2a6abf7158809cf4f3c.
  - T+12: done=1 for one cycle.
- Backpressure: same vector, ready low on alternate cycles → identical key sequence, with each key held stable while ready=0; total 11 transfers, and done only after the round-0 transfer.
- Start while busy: pulse start with a different last_key at round_idx=5 → sequence unaffected, busy stays 1.
- Reset mid-run: assert reset at round_idx=6 → next cycle all outputs 0, no done pulse; a fresh start then yields the full 10..0 sequence.
- Round-trip: random cipher key → forward expansion produces K10 → this block must reproduce all 11 forward round keys in reverse order (100 random keys).
- With AES_KEYREV_ZEROIZE_EN: after done, round_key=0 and the internal key_reg=0. Without the macro: key_reg holds the round-0 key.
